// File: rtl/osc_bank.sv
// Time-multiplexed phase-accumulator oscillator bank: VOICES voices share one adder and
// one waveform shaper, serviced round-robin one voice per clock, tagged output stream.
module osc_bank #(
  parameter int unsigned BITDEPTH    = 14,
  parameter int unsigned BITFRACTION = 6,
  parameter int unsigned VOICES      = 4,
  localparam int unsigned VB         = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic                reg_we,
  input  logic [VB+1:0]       reg_addr,
  input  logic [15:0]         reg_wdata,
  output logic [BITDEPTH-1:0] out,
  output logic [VB-1:0]       out_voice,
  output logic                out_valid
);

  localparam int unsigned AccW = BITDEPTH + BITFRACTION;
  localparam logic [BITDEPTH-1:0] Max     = '1;
  localparam logic [BITDEPTH-1:0] Mid     = {1'b0, {(BITDEPTH-1){1'b1}}};
  localparam logic [BITDEPTH-1:0] PwReset = {1'b1, {(BITDEPTH-1){1'b0}}};

  typedef enum logic [2:0] {
    WaveSaw   = 3'd0,
    WaveTri   = 3'd1,
    WavePulse = 3'd2,
    WaveSub   = 3'd3,
    WaveNoise = 3'd4
  } wave_e;

  logic [15:0]         inc_q  [VOICES];
  logic [BITDEPTH-1:0] pw_q   [VOICES];
  logic [4:0]          ctrl_q [VOICES];
  logic [AccW-1:0]     acc_q  [VOICES];
  logic                sub_q  [VOICES];
  logic [14:0]         lfsr_q [VOICES];

  logic [VB-1:0]       p_q;
  logic                last_wrap_q;
  logic [BITDEPTH-1:0] out_q;
  logic [VB-1:0]       out_voice_q;
  logic                out_valid_q;

  logic [AccW:0]       sum;
  logic [AccW-1:0]     acc_d;
  logic                sub_d;
  logic [14:0]         lfsr_d;
  logic                wrap;
  logic                last_wrap_d;
  logic [BITDEPTH-1:0] ph;
  logic [BITDEPTH-1:0] tri_src;
  logic [BITDEPTH-1:0] pulse;
  logic [BITDEPTH-1:0] sample;
  logic [4:0]          ctrl_cur;
  wave_e               wave;

  logic [VB-1:0]       wr_voice;
  logic [1:0]          wr_field;
  logic                wr_hit;

  assign ctrl_cur = ctrl_q[p_q];
  assign wave     = wave_e'(ctrl_cur[2:0]);
  assign sum      = {1'b0, acc_q[p_q]} + {{(AccW + 1 - 16){1'b0}}, inc_q[p_q]};

  always_comb begin
    acc_d       = acc_q[p_q];
    sub_d       = sub_q[p_q];
    lfsr_d      = lfsr_q[p_q];
    wrap        = 1'b0;
    last_wrap_d = 1'b0;
    if (ctrl_cur[4]) begin
      wrap  = sum[AccW];
      acc_d = sum[AccW-1:0];
      // Hard sync: the previously serviced voice wrapped, so restart and suppress our wrap.
      if (ctrl_cur[3] && last_wrap_q) begin
        acc_d = '0;
        wrap  = 1'b0;
      end
      if (wrap) begin
        sub_d  = ~sub_q[p_q];
        lfsr_d = {lfsr_q[p_q][13:0], lfsr_q[p_q][14] ^ lfsr_q[p_q][13]};
      end
      last_wrap_d = wrap;
    end
  end

  assign ph    = acc_d[AccW-1 -: BITDEPTH];
  assign pulse = (ph < pw_q[p_q]) ? Max : '0;

  // Triangle folds on the MSB; the bit below the accumulator LSB reads as zero.
  if (BITFRACTION > 0) begin : g_tri_frac
    assign tri_src = acc_d[AccW-2 -: BITDEPTH];
  end else begin : g_tri_nofrac
    assign tri_src = {acc_d[AccW-2:0], 1'b0};
  end

  always_comb begin
    sample = Mid;
    if (ctrl_cur[4]) begin
      unique case (wave)
        WaveSaw:   sample = ph;
        WaveTri:   sample = acc_d[AccW-1] ? ~tri_src : tri_src;
        WavePulse: sample = pulse;
        WaveSub:   sample = sub_d ? ~pulse : pulse;
        WaveNoise: sample = lfsr_d[0] ? Max : '0;
        default:   sample = Mid;
      endcase
    end
  end

  assign wr_voice = reg_addr[VB+1:2];
  assign wr_field = reg_addr[1:0];
  assign wr_hit   = reg_we && (32'(wr_voice) < VOICES);

  always_ff @(posedge sample_clock) begin
    if (rst) begin
      p_q         <= '0;
      last_wrap_q <= 1'b0;
      out_q       <= Mid;
      out_voice_q <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(VOICES); i++) begin
        inc_q[i]  <= '0;
        pw_q[i]   <= PwReset;
        ctrl_q[i] <= '0;
        acc_q[i]  <= '0;
        sub_q[i]  <= 1'b0;
        lfsr_q[i] <= 15'h0001;
      end
    end else begin
      p_q         <= (p_q == VB'(VOICES - 1)) ? '0 : p_q + 1'b1;
      last_wrap_q <= last_wrap_d;
      acc_q[p_q]  <= acc_d;
      sub_q[p_q]  <= sub_d;
      lfsr_q[p_q] <= lfsr_d;
      out_q       <= sample;
      out_voice_q <= p_q;
      out_valid_q <= 1'b1;
      if (wr_hit) begin
        unique case (wr_field)
          2'd0:    inc_q[wr_voice]  <= reg_wdata;
          2'd1:    pw_q[wr_voice]   <= reg_wdata[BITDEPTH-1:0];
          2'd2:    ctrl_q[wr_voice] <= reg_wdata[4:0];
          default: ;
        endcase
      end
    end
  end

  assign out       = out_q;
  assign out_voice = out_voice_q;
  assign out_valid = out_valid_q;

endmodule
